// File: rtl/lpm_ff_arb_pkg.sv
// Shared encodings for the lpm_ff sequencer/arbiter.
// Commands are the 2-bit per-requester cmd field; states are the controller FSM.
package lpm_ff_arb_pkg;

  typedef enum logic [1:0] {
    CMD_LOAD   = 2'b00,
    CMD_CLEAR  = 2'b01,
    CMD_SET    = 2'b10,
    CMD_TOGGLE = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } state_e;

endpackage

// File: rtl/lpm_rr_pick.sv
// Combinational requester picker: searches from (ptr+1) mod NUM_REQ upward.
// Holding ptr at NUM_REQ-1 turns it into lowest-index-wins fixed priority.
module lpm_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               valid
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    valid = |req;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/lpm_ff_arb.sv
// Arbiter/sequencer driving one shared lpm_ff (DFF) for NUM_REQ requesters.
// Define LPM_FF_ARB_RR_EN for round-robin; otherwise fixed priority, lowest index wins.
//
// state    | meaning
// ST_IDLE  | waiting for any req; grant, command and operand captured on exit
// ST_ISSUE | ff_enable plus one of sclr/sset/sload driven to the lpm_ff
// ST_RESP  | ack pulse to the granted requester, rdata = updated ff_q
module lpm_ff_arb
  import lpm_ff_arb_pkg::*;
#(
  parameter int LPM_WIDTH = 8,
  parameter int NUM_REQ   = 4
) (
  input  logic                         clock,
  input  logic                         sclr_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [2*NUM_REQ-1:0]         cmd,
  input  logic [LPM_WIDTH*NUM_REQ-1:0] wdata,
  output logic [NUM_REQ-1:0]           ack,
  output logic [LPM_WIDTH-1:0]         rdata,
  output logic                         busy,
  input  logic [LPM_WIDTH-1:0]         ff_q,
  output logic [LPM_WIDTH-1:0]         ff_data,
  output logic                         ff_enable,
  output logic                         ff_sclr,
  output logic                         ff_sset,
  output logic                         ff_sload
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [LPM_WIDTH-1:0] ff_data_q, ff_data_d;
  logic                 ff_enable_q, ff_enable_d;
  logic                 ff_sclr_q, ff_sclr_d;
  logic                 ff_sset_q, ff_sset_d;
  logic                 ff_sload_q, ff_sload_d;

  logic [IW-1:0]        ptr;
  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic                 pick_valid;
  cmd_e                 cmd_sel;
  logic [LPM_WIDTH-1:0] wd_sel;

`ifdef LPM_FF_ARB_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = IW'(NUM_REQ - 1);
`endif

  lpm_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    cmd_sel = CMD_LOAD;
    wd_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IW'(i)) begin
        cmd_sel = cmd_e'(cmd[2*i +: 2]);
        wd_sel  = wdata[LPM_WIDTH*i +: LPM_WIDTH];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    ack_d       = '0;
    ff_data_d   = ff_data_q;
    ff_enable_d = 1'b0;
    ff_sclr_d   = 1'b0;
    ff_sset_d   = 1'b0;
    ff_sload_d  = 1'b0;
`ifdef LPM_FF_ARB_RR_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d     = ST_ISSUE;
          gnt_d       = pick_gnt;
          ff_enable_d = 1'b1;
`ifdef LPM_FF_ARB_RR_EN
          ptr_d       = pick_idx;
`endif
          case (cmd_sel)
            CMD_CLEAR: ff_sclr_d = 1'b1;
            CMD_SET:   ff_sset_d = 1'b1;
            CMD_LOAD: begin
              ff_sload_d = 1'b1;
              ff_data_d  = wd_sel;
            end
            default: begin
              // ff_q is stable until ISSUE, so the read-modify-write is coherent
              ff_sload_d = 1'b1;
              ff_data_d  = ff_q ^ wd_sel;
            end
          endcase
        end
      end
      ST_ISSUE: begin
        state_d = ST_RESP;
        ack_d   = gnt_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      ack_q       <= '0;
      ff_data_q   <= '0;
      ff_enable_q <= 1'b0;
      ff_sclr_q   <= 1'b0;
      ff_sset_q   <= 1'b0;
      ff_sload_q  <= 1'b0;
`ifdef LPM_FF_ARB_RR_EN
      ptr_q       <= IW'(NUM_REQ - 1);
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      ack_q       <= ack_d;
      ff_data_q   <= ff_data_d;
      ff_enable_q <= ff_enable_d;
      ff_sclr_q   <= ff_sclr_d;
      ff_sset_q   <= ff_sset_d;
      ff_sload_q  <= ff_sload_d;
`ifdef LPM_FF_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  // Gating with sclr_n keeps a reset that lands in ISSUE from writing the lpm_ff
  assign ff_enable = ff_enable_q & sclr_n;
  assign ff_sclr   = ff_sclr_q & sclr_n;
  assign ff_sset   = ff_sset_q & sclr_n;
  assign ff_sload  = ff_sload_q & sclr_n;
  assign ff_data   = ff_data_q;
  assign ack       = ack_q;
  assign busy      = (state_q != ST_IDLE);
  assign rdata     = (|ack_q) ? ff_q : '0;

endmodule

// File: doc/lpm_ff_arb.md
# lpm_ff_arb

Sequencer/arbiter sharing a single `lpm_ff` register, configured as DFF with `lpm_width = LPM_WIDTH`, among `NUM_REQ` requesters. Each requester posts one of four commands: LOAD, CLEAR, SET or TOGGLE. The block grants one requester at a time and drives the register's `enable`, `sclr`, `sset`, `sload` and `data` inputs for exactly one clock. It then acknowledges the requester and returns the post-update register value. It sits between client logic and the shared `lpm_ff` instance; the `lpm_ff` itself is instantiated outside this block.

## Interface
- `LPM_WIDTH`, default 8: register width.
- `NUM_REQ`, default 4: number of requesters (2..8).
- `clock`  in  1: rising-edge clock; the only clock.
- `sclr_n`  in  1: reset, synchronous, active-low.
- `req`  in  NUM_REQ: request per requester; held high until its `ack`.
- `cmd`  in  2*NUM_REQ: command per requester. 00 = LOAD, 01 = CLEAR, 10 = SET, 11 = TOGGLE.
- `wdata`  in  LPM_WIDTH*NUM_REQ: load value (LOAD) or toggle mask (TOGGLE), per requester.
- `ack`  out  NUM_REQ: one-hot, one-cycle completion pulse.
- `rdata`  out  LPM_WIDTH: register value after the update; valid while any `ack` bit is high.
- `busy`  out  1: high whenever the FSM is not in IDLE.
- `ff_q`  in  LPM_WIDTH: `q` of the shared `lpm_ff`.
- `ff_data`  out  LPM_WIDTH: drives the `lpm_ff` `data` input.
- `ff_enable`, `ff_sclr`, `ff_sset`, `ff_sload`  out  1 each: drive the matching `lpm_ff` inputs.

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE → ISSUE when `|req`. At that edge the block registers:
  - the grant index `g`;
  - `cmd[g]`;
  - the operand, which is `wdata[g]` for LOAD and `ff_q ^ wdata[g]` for TOGGLE.
- ISSUE (one cycle): `ff_enable = 1`, plus exactly one of:
  - CLEAR → `ff_sclr = 1`.
  - SET → `ff_sset = 1`. The set value comes from the `lpm_ff` instance's `lpm_svalue`.
  - LOAD or TOGGLE → `ff_sload = 1`, with `ff_data` = the registered operand.
- ISSUE → RESP unconditionally. The `lpm_ff` updates on this edge.
- RESP (one cycle):
  - `ack[g] = 1`;
  - `rdata = ff_q` (combinational pass-through of the updated value);
  - all `ff_*` controls are 0.
- RESP → IDLE unconditionally.
- All `ff_*` outputs are registered and are 0 outside ISSUE.
- `ff_data` holds its last value outside ISSUE; this is don't-care while `ff_sload = 0`.
- `rdata` is 0 when no `ack` bit is high.
- The arbiter samples `req` only in IDLE. A `req` still high in the cycle after its `ack` counts as a new request.
- `cmd` and `wdata` changes after the IDLE → ISSUE edge are ignored until the next grant.
- This block is the register's only writer. The `lpm_ff` `aclr`, `aset` and `aload` inputs are tied inactive outside this block.
- TOGGLE is read-modify-write. This is coherent because `ff_q` cannot change between capture and issue.
- Reset (`sclr_n = 0` at an edge), taking effect at that edge:
  - state → IDLE;
  - `ack`, `ff_*`, `busy` → 0;
  - grant pointer → `NUM_REQ-1`, so requester 0 wins first;
  - the register contents are left untouched.
- Reset during ISSUE or RESP aborts the operation:
  - no `ack` is issued;
  - if reset lands in ISSUE, `ff_*` drop at the same edge the `lpm_ff` samples, so the write does not occur.

## Timing
- A request seen in IDLE at edge t gives ISSUE in cycle t+1, the register update at edge t+2, and `ack` in cycle t+2.
- Peak throughput: one operation per 3 cycles.
- Worst-case wait under round-robin: `3*(NUM_REQ-1)` cycles before the grant.

## Configuration
- `LPM_FF_ARB_RR_EN` defined: round-robin arbitration. Search starts at `(last_grant+1) mod NUM_REQ`; the pointer updates on each grant.
- `LPM_FF_ARB_RR_EN` undefined: fixed priority, lowest index wins. No pointer register exists.

## Structure
- Shared package/include `lpm_ff_arb_pkg` holds:
  - command encodings `CMD_LOAD`, `CMD_CLEAR`, `CMD_SET`, `CMD_TOGGLE`;
  - state encodings `ST_IDLE`, `ST_ISSUE`, `ST_RESP`.
- One sub-module, `lpm_rr_pick`: combinational one-hot/index picker taking `req` and a pointer. It also implements fixed priority when the pointer is forced to `NUM_REQ-1`.

## Test plan
- Reset, then `req = 0001`, `cmd0 = LOAD`, `wdata0 = 8'hA5` → `ff_enable = ff_sload = 1` in cycle t+1 with `ff_data = A5`; `ack = 0001` and `rdata = A5` in t+2.
- Register holds `8'h0F`; `req1` with TOGGLE, mask `8'hFF` → `ff_data = F0`; `rdata = F0` at ack.
- CLEAR then SET, with `lpm_svalue` unset → `rdata = 00`, then `FF`. Exactly one of `ff_sclr`/`ff_sset` is high per ISSUE cycle.
- `req = 1111` held, all LOAD with distinct data:
  - RR build → acks in order 0, 1, 2, 3, 0, each 3 cycles apart.
  - Non-RR build → requester 0 wins until it drops `req`.
- `sclr_n` low during ISSUE → no `ack`; register keeps its prior value; state IDLE after release.
- `cmd`/`wdata` changed during ISSUE → issued operand unchanged; `busy` is high only in ISSUE and RESP.
